// File: rtl/al_accel_wbuf_ctrl.sv
// Weight-buffer sequencer: fetches 3x3 kernels over a single-outstanding word
// bus, loads them into the buffer in three banks and steps columns to the MAC.
module al_accel_wbuf_ctrl #(
  parameter int unsigned KERN_STRIDE = 9,
  parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_addr,
  input  logic [7:0]  cfg_num_kern,
  output logic        busy,
  output logic        done,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wbuf_di,
  output logic [7:0]  wbuf_init,
  output logic [1:0]  wbuf_wstrb,
  output logic        wbuf_ld_wrn,
  output logic [1:0]  wbuf_bank_sel,
  output logic        wbuf_enb,
  output logic        col_valid,
  output logic [1:0]  col_idx,
  output logic [7:0]  kern_idx,
  input  logic        col_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | word read for the current bank outstanding
  // WRITE | one-cycle bank load into the weight buffer
  // COL   | column presented to the MAC array
  // FIN   | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, COL, FIN} state_t;

  state_t      state, state_nx;
  logic [31:0] kp, kp_nx;
  logic [7:0]  num_kern, num_kern_nx;
  logic [7:0]  kern_idx_nx;
  logic [1:0]  bank, bank_nx;
  logic [1:0]  bank_off;
  logic [1:0]  col_idx_nx;
  logic [31:0] di_nx;
  logic        last_kern;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      kp       <= 32'd0;
      num_kern <= 8'd0;
      bank     <= 2'd1;
      wbuf_di  <= 32'd0;
      col_idx  <= 2'd0;
      kern_idx <= 8'd0;
    end else begin
      state    <= state_nx;
      kp       <= kp_nx;
      num_kern <= num_kern_nx;
      bank     <= bank_nx;
      wbuf_di  <= di_nx;
      col_idx  <= col_idx_nx;
      kern_idx <= kern_idx_nx;
    end
  end

  // Widened so kern_idx+1 cannot wrap against the kernel count
  assign last_kern = ({1'b0, kern_idx} + 9'd1) >= {1'b0, num_kern};
  assign bank_off  = bank - 2'd1;

  always_comb begin
    state_nx    = state;
    kp_nx       = kp;
    num_kern_nx = num_kern;
    bank_nx     = bank;
    di_nx       = wbuf_di;
    col_idx_nx  = col_idx;
    kern_idx_nx = kern_idx;
    wbuf_enb    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          kp_nx       = cfg_addr;
          num_kern_nx = cfg_num_kern;
          kern_idx_nx = 8'd0;
          bank_nx     = 2'd1;
          state_nx    = (cfg_num_kern == 8'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          di_nx    = mem_rdata;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        wbuf_enb = 1'b1;
        if (bank == 2'd3) begin
          col_idx_nx = 2'd0;
          state_nx   = COL;
        end else begin
          bank_nx  = bank + 2'd1;
          state_nx = FETCH;
        end
      end
      COL: begin
        if (col_ready) begin
          if (col_idx != 2'd2) begin
            wbuf_enb   = 1'b1;
            col_idx_nx = col_idx + 2'd1;
          end else if (!last_kern) begin
            kp_nx       = kp + 32'(KERN_STRIDE);
            kern_idx_nx = kern_idx + 8'd1;
            bank_nx     = 2'd1;
            state_nx    = FETCH;
          end else begin
            state_nx = FIN;
          end
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign mem_valid     = (state == FETCH);
  assign mem_addr      = (state == FETCH) ?
                         ({kp[31:2], 2'b00} + {28'd0, bank_off, 2'b00}) : 32'd0;
  assign wbuf_init     = INIT_BYTE;
  assign wbuf_wstrb    = kp[1:0];
  assign wbuf_ld_wrn   = (state == WRITE);
  assign wbuf_bank_sel = (state == WRITE) ? bank : 2'd0;
  assign col_valid     = (state == COL);

endmodule

// File: doc/al_accel_wbuf_ctrl.md
# al_accel_wbuf_ctrl

Sequencer for the accelerator's 3x3 weight buffer (9 bytes, three 8-bit row outputs taken from byte lanes 0/3/6). For each of `cfg_num_kern` kernels, it fetches the kernel's 9 bytes from a byte-aligned address over a single-outstanding word-read bus. It loads them into the weight buffer in three bank writes whose byte strobe follows the address alignment. It then steps the buffer through its three columns under a valid/ready handshake with the MAC array. The block sits between the SoC memory port and the weight buffer, and is started by the accelerator's top-level control.

## Interface
Parameters:
- `KERN_STRIDE`, default 9: byte distance between consecutive kernels (1..255).
- `INIT_BYTE`, default 8'h00: byte driven on `wbuf_init`, shifted into the top of the buffer.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE, ignored while `busy`.
- `cfg_addr`  in  32: byte address of kernel 0; sampled with `start`.
- `cfg_num_kern`  in  8: number of kernels; sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the job finishes.
- `mem_valid`  out  1: read request.
- `mem_addr`  out  32: word address; bits [1:0] are always 0.
- `mem_ready`  in  1: read completes this cycle; `mem_rdata` is valid.
- `mem_rdata`  in  32: read data.
- `wbuf_di`  out  32: buffer write data (registered copy of `mem_rdata`).
- `wbuf_init`  out  8: constant `INIT_BYTE`.
- `wbuf_wstrb`  out  2: byte alignment of the current kernel address.
- `wbuf_ld_wrn`  out  1: 1 = bank load, 0 = shift.
- `wbuf_bank_sel`  out  2: 1/2/3 during loads; 0 otherwise.
- `wbuf_enb`  out  1: buffer enable; one-cycle pulse per load or shift.
- `col_valid`  out  1: a buffer column is presented on the buffer outputs.
- `col_idx`  out  2: column number, 0..2.
- `kern_idx`  out  8: index of the current kernel.
- `col_ready`  in  1: MAC consumed the column.

## Operation
- States: IDLE, FETCH, WRITE, COL, FIN.
- Reset values (asynchronous):
  - State is IDLE.
  - `busy`, `done`, `mem_valid`, `wbuf_enb`, `wbuf_ld_wrn`, `col_valid` are 0.
  - `mem_addr`, `wbuf_di`, `wbuf_wstrb`, `wbuf_bank_sel`, `col_idx`, `kern_idx` are 0.
- IDLE, on `start`:
  - Latch `cfg_addr` into a kernel pointer `kp`, latch `cfg_num_kern`, set `kern_idx`=0.
  - If `cfg_num_kern`=0, go to FIN. Otherwise go to FETCH with bank=1.
- FETCH:
  - Drive `mem_valid`=1 and `mem_addr`=(`kp` & ~3) + 4*(bank-1).
  - Address and bank are held stable until `mem_ready`.
  - On `mem_ready`, capture `mem_rdata` into `wbuf_di` and go to WRITE.
- WRITE (exactly one cycle):
  - Drive `wbuf_enb`=1, `wbuf_ld_wrn`=1, `wbuf_bank_sel`=bank, `wbuf_wstrb`=`kp`[1:0].
  - If bank<3: bank+1, go to FETCH.
  - If bank=3: go to COL with `col_idx`=0.
- Load pattern: every kernel takes exactly 3 word reads regardless of alignment. With offset o=`kp`[1:0], bank 1 supplies 4-o bytes, bank 2 supplies 4, bank 3 supplies o+1.
- COL:
  - Drive `col_valid`=1.
  - On `col_ready` with `col_idx`<2: pulse `wbuf_enb`=1 with `wbuf_ld_wrn`=0 (shift) in the same cycle, then `col_idx`+1.
  - On `col_ready` with `col_idx`=2: no shift.
    - If `kern_idx`+1 < count: `kp` += `KERN_STRIDE`, `kern_idx`+1, bank=1, go to FETCH.
    - Otherwise go to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^32; `kp` wraps silently.
- `start` asserted in FIN or in any busy state is dropped (not queued).
- `reset` asserted mid-fetch drops `mem_valid` immediately. A late `mem_ready` arriving after reset is ignored.

## Timing
- Cycle 0: `start` sampled. Cycle 1: first `mem_valid`.
- `mem_ready` is allowed in the same cycle `mem_valid` rises. Each bank then costs 2 cycles (FETCH + WRITE).
- Minimum per kernel: 6 load cycles + 3 COL cycles = 9 cycles.
- With zero-wait memory and `col_ready` held at 1, an N-kernel job has `done` at cycle 1+9N.
- A bank write always occurs exactly 1 cycle after its `mem_ready`.
- `col_valid` rises the cycle after the bank-3 write.
- Shift takes effect at the clock edge ending the handshake cycle; the next column is visible the following cycle.
- `col_valid` stays high while `col_ready` is 0. Buffer outputs are stable during the stall (`wbuf_enb`=0).

## Test plan
- **Aligned kernel.** `cfg_addr`=0x100, N=1, memory words 0x03020100, 0x07060504, 0x0B0A0908, zero wait.
  - Reads from 0x100, 0x104, 0x108, all with `wbuf_wstrb`=0.
  - Columns (do_0, do_1, do_2) = (00,03,06), (01,04,07), (02,05,08).
  - `done` at cycle 10.
- **Unaligned kernel.** `cfg_addr`=0x103, same memory image.
  - `wbuf_wstrb`=3 on all three writes; reads from 0x100, 0x104, 0x108.
  - Column 0 = (03,06,09).
- **Two kernels, stride 9.** `cfg_addr`=0x200.
  - Kernel 1 fetch starts at word 0x208 with `wbuf_wstrb`=1.
  - `kern_idx` reads 0, then 1; a single `done` pulse at cycle 19.
- **Backpressure.** `mem_ready` delayed 3 cycles, `col_ready` low for 4 cycles on column 1.
  - `mem_addr` is held during the wait; no `wbuf_enb` during the stall.
  - Column data does not change during the stall.
- **Edge cases.**
  - N=0: `done` at cycle 1, no `mem_valid`.
  - `start` pulsed while busy: ignored.
  - `cfg_addr`=0xFFFFFFFE: reads from 0xFFFFFFFC, 0x00000000, 0x00000004.
- **Reset mid-op.** Assert `reset` during FETCH of bank 2.
  - `mem_valid` falls asynchronously and all outputs take their reset values.
  - A new `start` after release fetches from bank 1.
